// File: rtl/updown_bound_counter.sv
// Up/down counter with programmable step and bounds, wrap/saturate/one-shot
// overflow handling, and an IDLE/RUN/DONE run-control FSM.
module updown_bound_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  init_val,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic              start,
  input  logic              stop,
  input  logic              up,
  input  logic              down,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              tc,
  output logic              at_max,
  output logic              at_min,
  output logic              cfg_err
);

  localparam int EW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic               busy_q;
  logic               done_q;
  logic               tc_q;

  logic [STEP_W-1:0]  step_eff;
  logic [EW-1:0]      cnt_ext;
  logic [EW-1:0]      step_ext;
  logic [EW-1:0]      min_ext;
  logic [EW-1:0]      max_ext;
  logic [EW-1:0]      up_ideal;
  logic [EW-1:0]      down_ideal;
  logic               borrow;
  logic               up_hit;
  logic               up_past;
  logic               down_hit;
  logic               down_past;
  logic               is_sat;
  logic               is_one;
  logic [WIDTH-1:0]   init_clamped;
  logic [WIDTH-1:0]   count_d;
  logic               tc_d;
  logic               hit_d;

  assign step_eff = (step == '0) ? STEP_W'(1) : step;
  assign cnt_ext  = {1'b0, count_q};
  assign step_ext = {{(EW - STEP_W){1'b0}}, step_eff};
  assign min_ext  = {1'b0, min_val};
  assign max_ext  = {1'b0, max_val};

  // Extra bit keeps the sum exact; borrow flags a difference that went below zero.
  assign up_ideal   = cnt_ext + step_ext;
  assign down_ideal = cnt_ext - step_ext;
  assign borrow     = cnt_ext < step_ext;

  assign up_hit    = up_ideal >= max_ext;
  assign up_past   = up_ideal > max_ext;
  assign down_hit  = borrow || (down_ideal <= min_ext);
  assign down_past = borrow || (down_ideal < min_ext);

  assign is_sat = (mode == 2'b01);
  assign is_one = (mode == 2'b10);

  assign init_clamped = (init_val < min_val) ? min_val :
                        (init_val > max_val) ? max_val : init_val;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    hit_d   = 1'b0;
    if (up) begin
      if (up_hit) begin
        hit_d   = 1'b1;
        count_d = (is_sat || is_one || !up_past) ? max_val : min_val;
        tc_d    = !(is_sat && (count_q == max_val));
      end else begin
        count_d = up_ideal[WIDTH-1:0];
      end
    end else begin
      if (down_hit) begin
        hit_d   = 1'b1;
        count_d = (is_sat || is_one || !down_past) ? min_val : max_val;
        tc_d    = !(is_sat && (count_q == min_val));
      end else begin
        count_d = down_ideal[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= init_clamped;
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count_q <= init_clamped;
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (stop && (state_q != S_DONE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (start && !cfg_err && (state_q != S_RUN)) begin
        if (state_q == S_DONE) begin
          count_q <= init_clamped;
        end
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if ((state_q == S_RUN) && !cfg_err && (up ^ down)) begin
        count_q <= count_d;
        tc_q    <= tc_d;
        if (is_one && hit_d) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tc      = tc_q;
  assign at_max  = (count_q == max_val);
  assign at_min  = (count_q == min_val);
  assign cfg_err = (min_val > max_val);

endmodule

// File: tb/tb_updown_bound_counter.sv
// Directed-vector bench: stimulus queues expected outputs, a negedge monitor
// pops and compares them against the DUT.
module tb_updown_bound_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] init_val, min_val, max_val;
  logic [3:0] step;
  logic [1:0] mode;
  logic       load, start, stop, up, down;
  logic [7:0] count;
  logic       busy, done, tc, at_max, at_min, cfg_err;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       tc;
    logic       at_max;
    logic       at_min;
    logic       cfg_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  updown_bound_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .reset(reset), .init_val(init_val), .min_val(min_val),
    .max_val(max_val), .step(step), .mode(mode), .load(load), .start(start),
    .stop(stop), .up(up), .down(down), .count(count), .busy(busy),
    .done(done), .tc(tc), .at_max(at_max), .at_min(at_min), .cfg_err(cfg_err)
  );

  // One clock edge; queue the expected post-edge state, return at negedge+1.
  task automatic tick(input string nm, input logic [7:0] c, input logic b,
                      input logic d, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    e.name    = nm;
    e.cnt     = c;
    e.busy    = b;
    e.done    = d;
    e.tc      = t;
    e.at_max  = (c == max_val);
    e.at_min  = (c == min_val);
    e.cfg_err = (min_val > max_val);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] got, want;
      e    = exp_q.pop_front();
      got  = {count, busy, done, tc, at_max, at_min, cfg_err};
      want = {e.cnt, e.busy, e.done, e.tc, e.at_max, e.at_min, e.cfg_err};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s: got count=%02h busy=%b done=%b tc=%b at_max=%b at_min=%b cfg_err=%b, expected count=%02h busy=%b done=%b tc=%b at_max=%b at_min=%b cfg_err=%b",
                 e.name, count, busy, done, tc, at_max, at_min, cfg_err,
                 e.cnt, e.busy, e.done, e.tc, e.at_max, e.at_min, e.cfg_err);
      end else begin
        $display("check %s: count=%02h busy=%b done=%b tc=%b", e.name, count, busy, done, tc);
      end
    end
  end

  initial begin
    reset = 1'b0; init_val = 8'h20; min_val = 8'h10; max_val = 8'hF0;
    step = 4'd1; mode = 2'b00; load = 0; start = 0; stop = 0; up = 0; down = 0;

    tick("reset0", 8'h20, 0, 0, 0);
    tick("reset1", 8'h20, 0, 0, 0);
    reset = 1'b1;

    init_val = 8'h05; load = 1;
    tick("load_clamp_low", 8'h10, 0, 0, 0);

    // Wrap up, step 3
    init_val = 8'hEA; mode = 2'b00; step = 4'd3;
    tick("load_EA", 8'hEA, 0, 0, 0);
    load = 0; start = 1;
    tick("start_wrap", 8'hEA, 1, 0, 0);
    start = 0; up = 1;
    tick("wrap_up1", 8'hED, 1, 0, 0);
    tick("wrap_up_eq_max", 8'hF0, 1, 0, 1);
    tick("wrap_up_past", 8'h10, 1, 0, 1);
    tick("wrap_up4", 8'h13, 1, 0, 0);
    up = 0; stop = 1;
    tick("stop_hold", 8'h13, 0, 0, 0);

    // Saturate down, step 4
    stop = 0; init_val = 8'h16; load = 1; mode = 2'b01; step = 4'd4;
    tick("load_16", 8'h16, 0, 0, 0);
    load = 0; start = 1;
    tick("start_sat", 8'h16, 1, 0, 0);
    start = 0; down = 1;
    tick("sat_dn1", 8'h12, 1, 0, 0);
    tick("sat_dn_hit", 8'h10, 1, 0, 1);
    tick("sat_dn_hold1", 8'h10, 1, 0, 0);
    tick("sat_dn_hold2", 8'h10, 1, 0, 0);
    down = 0; init_val = 8'h12; load = 1;
    tick("load_12", 8'h12, 0, 0, 0);
    load = 0; start = 1;
    tick("start_step0", 8'h12, 1, 0, 0);
    start = 0; step = 4'd0; down = 1;
    tick("step0_as_1", 8'h11, 1, 0, 0);
    down = 0;

    // One-shot up
    mode = 2'b10; step = 4'd1; init_val = 8'hEE; load = 1;
    tick("load_EE", 8'hEE, 0, 0, 0);
    load = 0; start = 1;
    tick("start_one", 8'hEE, 1, 0, 0);
    start = 0; up = 1;
    tick("one_up1", 8'hEF, 1, 0, 0);
    tick("one_hit", 8'hF0, 0, 1, 1);
    tick("one_after_done", 8'hF0, 0, 1, 0);
    up = 0; stop = 1;
    tick("stop_ignored_done", 8'hF0, 0, 1, 0);
    stop = 0; init_val = 8'h30; start = 1;
    tick("restart_from_done", 8'h30, 1, 0, 0);
    start = 0;

    // Simultaneous events
    up = 1; down = 1;
    tick("up_and_down", 8'h30, 1, 0, 0);
    up = 0; down = 0; init_val = 8'h44; load = 1; start = 1;
    tick("load_and_start", 8'h44, 0, 0, 0);
    load = 0;
    tick("start_after_load", 8'h44, 1, 0, 0);
    start = 0; stop = 1; up = 1;
    tick("stop_freeze", 8'h44, 0, 0, 0);
    stop = 0; up = 0;
    tick("idle_hold", 8'h44, 0, 0, 0);

    // Reset mid-RUN
    mode = 2'b00; init_val = 8'h7F; load = 1;
    tick("load_7F", 8'h7F, 0, 0, 0);
    load = 0; start = 1;
    tick("start_7F", 8'h7F, 1, 0, 0);
    start = 0; up = 1;
    tick("up_to_80", 8'h80, 1, 0, 0);
    reset = 0; init_val = 8'h25;
    tick("reset_mid_run", 8'h25, 0, 0, 0);
    reset = 1; up = 0;

    // Wrap down with underflow below zero
    min_val = 8'h02; init_val = 8'h03; load = 1;
    tick("load_03", 8'h03, 0, 0, 0);
    load = 0; start = 1;
    tick("start_uf", 8'h03, 1, 0, 0);
    start = 0; step = 4'd8; down = 1;
    tick("wrap_dn_underflow", 8'hF0, 1, 0, 1);
    down = 0; min_val = 8'h10;

    // Config error
    min_val = 8'h80; max_val = 8'h40; up = 1;
    for (int i = 0; i < 3; i++) tick($sformatf("cfg_err_run_up%0d", i), 8'hF0, 1, 0, 0);
    up = 0; stop = 1;
    tick("cfg_err_stop", 8'hF0, 0, 0, 0);
    stop = 0; start = 1;
    tick("cfg_err_start_ignored", 8'hF0, 0, 0, 0);
    start = 0; up = 1;
    for (int i = 0; i < 10; i++) tick($sformatf("cfg_err_idle_up%0d", i), 8'hF0, 0, 0, 0);
    up = 0;

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_bound_counter.md
# updown_bound_counter

Parametrised up/down counter with programmable step, lower and upper bounds, and three overflow modes: wrap, saturate and one-shot. It is the general-purpose successor to the team's basic up/down counter and is used for timers, address walkers and event budgets. A small run-control FSM (IDLE/RUN/DONE) gates counting, and the block produces a registered terminal-count pulse and status flags.

## Interface
- `WIDTH`, 8, counter and bound width (≥2)
- `STEP_W`, 4, step input width (≤ WIDTH)
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `init_val`  in  WIDTH  value loaded on reset, `load`, and start-from-DONE; clamped to [min_val, max_val]
- `min_val`  in  WIDTH  lower bound, unsigned
- `max_val`  in  WIDTH  upper bound, unsigned
- `step`  in  STEP_W  increment magnitude; 0 is treated as 1
- `mode`  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- `load`  in  1  load clamp(init_val) and go to IDLE
- `start`  in  1  enter RUN
- `stop`  in  1  RUN → IDLE; count holds
- `up`  in  1  count up, effective in RUN only
- `down`  in  1  count down, effective in RUN only
- `count`  out  WIDTH  registered count
- `busy`  out  1  state == RUN
- `done`  out  1  state == DONE
- `tc`  out  1  registered one-cycle terminal-count pulse
- `at_max`  out  1  combinational (count == max_val)
- `at_min`  out  1  combinational (count == min_val)
- `cfg_err`  out  1  combinational (min_val > max_val)

## Operation
- Priority per edge: reset (low) > load > stop > start > count update.
- Reset values: count = clamp(init_val), state IDLE, busy 0, done 0, tc 0.
- clamp(x) = min_val if x < min_val; max_val if x > max_val; otherwise x.
- FSM transitions:
  - IDLE: start → RUN.
  - RUN: stop → IDLE. In one-shot mode, reaching a bound → DONE.
  - DONE: start → RUN with count = clamp(init_val). Stop is ignored in DONE.
  - Any state: load → IDLE with count = clamp(init_val).
- Count update occurs only in RUN with exactly one of `up`/`down` high. If both are high, or neither, count holds and tc = 0.
- Arithmetic uses WIDTH+1 bits with no truncation.
  - Up: ideal = count + s, where s = (step == 0 ? 1 : step).
  - Down: ideal = count − s, with borrow detected as ideal < min_val, including underflow below 0.
- A bound is "hit" when ideal ≥ max_val (up) or ideal ≤ min_val (down).
- Result on a hit:
  - Wrap: ideal passes the bound → count = min_val (up) or max_val (down); ideal equals the bound exactly → count = the bound.
  - Saturate: count = max_val (up) or min_val (down).
  - One-shot: same as saturate, and state → DONE.
- tc = 1 on the cycle after a hit edge, with one exception: in saturate mode, if count already equalled the bound before the edge, tc = 0. Holding at a saturated bound does not re-pulse.
- No hit: count = ideal.
- cfg_err = 1 inhibits both start and count updates. Load still operates; its clamp result is unspecified while cfg_err = 1.
- start while already in RUN: no effect.

## Timing
- All outputs except at_max, at_min and cfg_err are registered.
- start sampled at edge N → busy = 1 after N. The first count change occurs at edge N+1 if up or down is high.
- up/down sampled at edge N → count and tc are valid after N, giving 1-cycle latency. tc is high for exactly one cycle per hit edge.
- One-shot: the edge that hits the bound also sets done = 1 and busy = 0. Later up/down pulses have no effect.
- Asserting reset mid-RUN returns to reset values at that same edge, with no tc pulse.
- Bound or step changes while in RUN take effect at the next edge.

## Test plan
All scenarios use WIDTH=8, min_val=0x10, max_val=0xF0 unless noted.
- Reset and clamp: init_val=0x20, reset low for 2 cycles → count=0x20, busy=0, done=0, tc=0. Then init_val=0x05 with load → count=0x10, at_min=1.
- Wrap up: mode=00, step=3, count=0xEA, start, then up for 4 cycles → count sequence 0xED, 0xF0 (tc=1), 0x10 (tc=1), 0x13 (tc=0).
- Saturate down: mode=01, step=4, count=0x16, in RUN, down for 4 cycles → 0x12, 0x10 (tc=1), 0x10 (tc=0), 0x10 (tc=0). Also step=0 from 0x12 → 0x11.
- One-shot: mode=10, step=1, count=0xEE, up held → 0xEF, 0xF0 with tc=1, done=1, busy=0. Further up → still 0xF0. Then start with init_val=0x30 → count=0x30, busy=1.
- Simultaneous events:
  - up and down both high in RUN → count holds, tc=0.
  - load and start in the same cycle → count=clamp(init_val), state IDLE.
  - stop in RUN → busy=0 and count frozen.
  - reset low mid-RUN at count 0x80 → count=clamp(init_val), IDLE.
- Config error: min_val=0x80, max_val=0x40 → cfg_err=1; start ignored (busy stays 0); count unchanged for 10 cycles of up.
